// File: rtl/drive_pkg.sv
// drive_pkg
// Shared encodings for the car controller. The manual-drive decoder and
// drive_state_ctrl both import this package, so every power, car-state and
// moving-state value is defined in exactly one place.
package drive_pkg;

    // Power state
    localparam logic       POFF   = 1'b0;
    localparam logic       PON    = 1'b1;

    // Car state
    localparam logic [1:0] NSTART = 2'b00;
    localparam logic [1:0] START  = 2'b01;
    localparam logic [1:0] MOVING = 2'b10;

    // Moving state (one-hot, all-zero = no motion)
    localparam logic [3:0] NONE   = 4'b0000;
    localparam logic [3:0] FWD    = 4'b0001;
    localparam logic [3:0] BACK   = 4'b0010;
    localparam logic [3:0] LEFT   = 4'b0100;
    localparam logic [3:0] RIGHT  = 4'b1000;

    // Mileage saturation value
    localparam logic [23:0] MILEAGE_MAX = 24'hFF_FFFF;

endpackage

// File: rtl/tick_counter.sv
// tick_counter
// Modulo-N cycle counter with a terminal-count indication.
//   clk  : system clock
//   rst  : synchronous active-high reset (count -> 0)
//   en   : advance the count this cycle
//   clr  : synchronous clear, wins over en
//   tc   : high in the cycle where an enabled count sits at N-1; the count
//          wraps to 0 on that same edge
module tick_counter #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int unsigned W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    logic [W-1:0] cnt_r;

    // Terminal count: qualified by en so a paused counter never fires.
    always_comb begin
        tc = en && (cnt_r == LAST);
    end

    // Count register with clear priority over enable.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r <= ZERO;
        end else if (en) begin
            cnt_r <= (cnt_r == LAST) ? ZERO : (cnt_r + ONE);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/drive_state_ctrl.sv
// drive_state_ctrl
// Registered state holder for the car controller: power, car state and
// moving state fed back to the manual-drive decoder, plus power-on hold
// qualification, idle auto power-off, mileage counting and turn lights.
// Optional feature macro: DRIVE_BLINK_EN (lamps blink; otherwise steady).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pwr_on_btn, pwr_off_btn  conditioned button levels
//   next_power, next_state, next_moving_state, turn_left_req,
//   turn_right_req           decoder next-state outputs
//   power, state, moving_state, left_led, right_led, mileage, idle_off
//                            registered outputs
module drive_state_ctrl
    import drive_pkg::*;
#(
    parameter int unsigned PWR_HOLD_CYC = 100_000_000,
    parameter int unsigned IDLE_OFF_CYC = 1_000_000_000,
    parameter int unsigned MILE_CYC     = 100_000_000,
    parameter int unsigned BLINK_CYC    = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwr_on_btn,
    input  logic        pwr_off_btn,
    input  logic        next_power,
    input  logic [1:0]  next_state,
    input  logic [3:0]  next_moving_state,
    input  logic        turn_left_req,
    input  logic        turn_right_req,
    output logic        power,
    output logic [1:0]  state,
    output logic [3:0]  moving_state,
    output logic        left_led,
    output logic        right_led,
    output logic [23:0] mileage,
    output logic        idle_off
);

    logic        power_r;
    logic [1:0]  state_r;
    logic [3:0]  moving_state_r;
    logic        left_led_r;
    logic        right_led_r;
    logic [23:0] mileage_r;
    logic        idle_off_r;
    // Set while the power button is held during ON; forces a release
    // before a new hold can start counting.
    logic        hold_block_r;

    logic hold_en_s, hold_clr_s, hold_tc_s;
    logic idle_en_s, idle_clr_s, idle_tc_s;
    logic mile_en_s, mile_tc_s;
    logic power_on_s, stay_on_s;
    logic lamp_left_s, lamp_right_s;

    // Control qualifiers for the counters and the power decision.
    always_comb begin
        hold_en_s  = !power_r && pwr_on_btn && !hold_block_r;
        hold_clr_s = power_r || !pwr_on_btn || hold_block_r;
        idle_en_s  = power_r && (state_r != MOVING);
        idle_clr_s = !power_r || (state_r == MOVING);
        mile_en_s  = power_r && (state_r == MOVING) && (moving_state_r != NONE);
        power_on_s = !power_r && hold_tc_s;
        // Staying on requires no off button, no idle timeout and decoder consent.
        stay_on_s  = power_r && !pwr_off_btn && !idle_tc_s && next_power;
    end

    tick_counter #(.N(PWR_HOLD_CYC)) u_hold (
        .clk(clk), .rst(rst), .en(hold_en_s), .clr(hold_clr_s), .tc(hold_tc_s)
    );

    tick_counter #(.N(IDLE_OFF_CYC)) u_idle (
        .clk(clk), .rst(rst), .en(idle_en_s), .clr(idle_clr_s), .tc(idle_tc_s)
    );

    // The mileage sub-count restarts with each trip; it only holds across pauses.
    tick_counter #(.N(MILE_CYC)) u_mile (
        .clk(clk), .rst(rst), .en(mile_en_s), .clr(power_on_s), .tc(mile_tc_s)
    );

`ifdef DRIVE_BLINK_EN
    logic [1:0] req_prev_r;
    logic       phase_r;
    logic       phase_next_s;
    logic       req_change_s;
    logic       blink_clr_s;
    logic       blink_tc_s;

    // Blink phase: restart lit on power-off or any change of the request pair.
    always_comb begin
        req_change_s = ({turn_left_req, turn_right_req} != req_prev_r);
        blink_clr_s  = !power_r || req_change_s;
        if (blink_clr_s) begin
            phase_next_s = 1'b1;
        end else if (blink_tc_s) begin
            phase_next_s = !phase_r;
        end else begin
            phase_next_s = phase_r;
        end
        lamp_left_s  = turn_left_req && phase_next_s;
        lamp_right_s = turn_right_req && phase_next_s;
    end

    tick_counter #(.N(BLINK_CYC)) u_blink (
        .clk(clk), .rst(rst), .en(power_r), .clr(blink_clr_s), .tc(blink_tc_s)
    );

    // Blink phase and previous request pair registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_prev_r <= 2'b00;
            phase_r    <= 1'b1;
        end else begin
            req_prev_r <= {turn_left_req, turn_right_req};
            phase_r    <= phase_next_s;
        end
    end
`else
    // A zero half-period is meaningless in either build; keep lamps dark then.
    localparam logic LAMP_EN = (BLINK_CYC > 32'd0);

    // Steady lamps follow the requests directly.
    always_comb begin
        lamp_left_s  = turn_left_req && LAMP_EN;
        lamp_right_s = turn_right_req && LAMP_EN;
    end
`endif

    // Power, car state, idle pulse and hold-release tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            power_r        <= POFF;
            state_r        <= NSTART;
            moving_state_r <= NONE;
            idle_off_r     <= 1'b0;
            hold_block_r   <= 1'b0;
        end else begin
            power_r        <= (power_on_s || stay_on_s) ? PON : POFF;
            // Power-on, power-off and staying off all land in NSTART/NONE.
            state_r        <= stay_on_s ? next_state : NSTART;
            moving_state_r <= stay_on_s ? next_moving_state : NONE;
            idle_off_r     <= idle_tc_s;
            hold_block_r   <= pwr_on_btn && (hold_block_r || power_r);
        end
    end

    // Mileage: cleared at power-on, saturating increment per sub-count wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            mileage_r <= 24'd0;
        end else if (power_on_s) begin
            mileage_r <= 24'd0;
        end else if (mile_tc_s && (mileage_r != MILEAGE_MAX)) begin
            mileage_r <= mileage_r + 24'd1;
        end else begin
            mileage_r <= mileage_r;
        end
    end

    // Turn lights are dark whenever the car is (or is going) off.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_led_r  <= 1'b0;
            right_led_r <= 1'b0;
        end else begin
            left_led_r  <= stay_on_s && lamp_left_s;
            right_led_r <= stay_on_s && lamp_right_s;
        end
    end

    assign power        = power_r;
    assign state        = state_r;
    assign moving_state = moving_state_r;
    assign left_led     = left_led_r;
    assign right_led    = right_led_r;
    assign mileage      = mileage_r;
    assign idle_off     = idle_off_r;

endmodule
